// File: rtl/smart_systolic_seq_ctrl.sv
// Phase sequencer for one SMART systolic MAC tile: load, stream, flush, drain.
// Optional busy-cycle counter enabled by defining SMART_SEQ_CTRL_PERF_EN.
module smart_systolic_seq_ctrl #(
    parameter int CELL_HEIGHT = 4,
    parameter int CELL_WIDTH  = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_k_len,
    input  logic [1:0]       cfg_smart_in,
    input  logic [1:0]       cfg_smart_out,
    output logic             busy,
    output logic             done,
    output logic [2:0]       phase,
    output logic             ctl_stat_bit,
    output logic             ctl_op2_select,
    output logic             ctl_out_select,
    output logic             capture_smart_left_select,
    output logic             capture_smart_top_select,
    output logic             latch_smart_right_select,
    output logic             latch_smart_bottom_select,
    output logic             feed_top_vld,
    output logic             feed_left_vld,
    output logic             drain_vld,
    output logic [31:0]      perf_busy_cycles
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STREAM = 3'd2,
        S_FLUSH  = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LP_LOAD_LAST  = CNT_W'(CELL_HEIGHT - 1);
    localparam logic [CNT_W-1:0] LP_FLUSH_LAST = CNT_W'(CELL_HEIGHT + CELL_WIDTH - 2);
    localparam logic [CNT_W-1:0] LP_ONE        = CNT_W'(1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] r_k_len;
    logic [1:0]       r_smart_in;
    logic [1:0]       r_smart_out;
    logic [CNT_W-1:0] w_last_cnt;
    logic             w_last;
    logic             w_cfg_load;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_k_len     <= '0;
            r_smart_in  <= '0;
            r_smart_out <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_cfg_load) begin
                r_k_len     <= cfg_k_len;
                r_smart_in  <= cfg_smart_in;
                r_smart_out <= cfg_smart_out;
            end
        end
    end

    // Terminal count of the current phase; STREAM is never entered with K=0.
    always_comb begin
        w_last_cnt = '0;
        unique case (r_state)
            S_LOAD:   w_last_cnt = LP_LOAD_LAST;
            S_STREAM: w_last_cnt = r_k_len - LP_ONE;
            S_FLUSH:  w_last_cnt = LP_FLUSH_LAST;
            S_DRAIN:  w_last_cnt = LP_LOAD_LAST;
            default:  w_last_cnt = '0;
        endcase
    end

    assign w_last = (r_cnt == w_last_cnt);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_cfg_load  = 1'b0;
        if (r_state != S_IDLE && abort) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start && !abort) begin
                        w_cfg_load  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = (r_k_len == '0) ? S_FLUSH : S_STREAM;
                    end else begin
                        w_cnt_nxt = r_cnt + LP_ONE;
                    end
                end
                S_STREAM: begin
                    if (w_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_FLUSH;
                    end else begin
                        w_cnt_nxt = r_cnt + LP_ONE;
                    end
                end
                S_FLUSH: begin
                    if (w_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DRAIN;
                    end else begin
                        w_cnt_nxt = r_cnt + LP_ONE;
                    end
                end
                S_DRAIN: begin
                    if (w_last) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cnt_nxt = r_cnt + LP_ONE;
                    end
                end
                S_DONE: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign done  = (r_state == S_DONE);
    assign phase = r_state;

    assign ctl_stat_bit             = (r_state == S_LOAD);
    assign ctl_op2_select           = (r_state == S_LOAD);
    assign feed_top_vld             = (r_state == S_LOAD);
    assign capture_smart_top_select = (r_state == S_LOAD) && r_smart_in[1];

    assign feed_left_vld             = (r_state == S_STREAM);
    assign capture_smart_left_select = (r_state == S_STREAM) && r_smart_in[0];

    assign ctl_out_select            = (r_state == S_DRAIN);
    assign drain_vld                 = (r_state == S_DRAIN);
    assign latch_smart_right_select  = (r_state == S_DRAIN) && r_smart_out[0];
    assign latch_smart_bottom_select = (r_state == S_DRAIN) && r_smart_out[1];

`ifdef SMART_SEQ_CTRL_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf <= '0;
        end else if (busy && r_perf != 32'hFFFF_FFFF) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_busy_cycles = r_perf;
`else
    assign perf_busy_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_smart_systolic_seq_ctrl.sv
// Directed bench for smart_systolic_seq_ctrl with H=W=4, CNT_W=8.
// Per-cycle expectations follow the phase timeline relative to the start edge.
module tb_smart_systolic_seq_ctrl;

    localparam int H = 4;
    localparam int W = 4;

    logic        clk;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  cfg_k_len;
    logic [1:0]  cfg_smart_in;
    logic [1:0]  cfg_smart_out;
    logic        busy;
    logic        done;
    logic [2:0]  phase;
    logic        ctl_stat_bit;
    logic        ctl_op2_select;
    logic        ctl_out_select;
    logic        capture_smart_left_select;
    logic        capture_smart_top_select;
    logic        latch_smart_right_select;
    logic        latch_smart_bottom_select;
    logic        feed_top_vld;
    logic        feed_left_vld;
    logic        drain_vld;
    logic [31:0] perf_busy_cycles;
    logic [9:0]  dut_ctl;

    int checks = 0;
    int errors = 0;
    int exp_perf = 0;

    smart_systolic_seq_ctrl #(
        .CELL_HEIGHT(H),
        .CELL_WIDTH (W),
        .CNT_W      (8)
    ) u_dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .abort                     (abort),
        .cfg_k_len                 (cfg_k_len),
        .cfg_smart_in              (cfg_smart_in),
        .cfg_smart_out             (cfg_smart_out),
        .busy                      (busy),
        .done                      (done),
        .phase                     (phase),
        .ctl_stat_bit              (ctl_stat_bit),
        .ctl_op2_select            (ctl_op2_select),
        .ctl_out_select            (ctl_out_select),
        .capture_smart_left_select (capture_smart_left_select),
        .capture_smart_top_select  (capture_smart_top_select),
        .latch_smart_right_select  (latch_smart_right_select),
        .latch_smart_bottom_select (latch_smart_bottom_select),
        .feed_top_vld              (feed_top_vld),
        .feed_left_vld             (feed_left_vld),
        .drain_vld                 (drain_vld),
        .perf_busy_cycles          (perf_busy_cycles)
    );

    assign dut_ctl = {ctl_stat_bit, ctl_op2_select, ctl_out_select,
                      capture_smart_left_select, capture_smart_top_select,
                      latch_smart_right_select, latch_smart_bottom_select,
                      feed_top_vld, feed_left_vld, drain_vld};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Phase expected in cycle i after the start edge (i=1 is the first LOAD cycle).
    function automatic logic [2:0] exp_phase(input int i, input int k);
        if (i <= H)                     return 3'd1;
        else if (i <= H + k)            return 3'd2;
        else if (i <= 2*H + W - 1 + k)  return 3'd3;
        else if (i <= 3*H + W - 1 + k)  return 3'd4;
        else if (i == 3*H + W + k)      return 3'd5;
        else                            return 3'd0;
    endfunction

    // {stat, op2, out_sel, capL, capT, latR, latB, feedT, feedL, drain}
    function automatic logic [9:0] exp_ctl(input logic [2:0] ph,
                                           input logic [1:0] si,
                                           input logic [1:0] so);
        logic [9:0] v;
        v = '0;
        case (ph)
            3'd1: begin v[9] = 1'b1; v[8] = 1'b1; v[5] = si[1]; v[2] = 1'b1; end
            3'd2: begin v[6] = si[0]; v[1] = 1'b1; end
            3'd4: begin v[7] = 1'b1; v[4] = so[0]; v[3] = so[1]; v[0] = 1'b1; end
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] perf_req();
`ifdef SMART_SEQ_CTRL_PERF_EN
        return 32'(exp_perf);
`else
        return 32'd0;
`endif
    endfunction

    // Runs one job; abort_at/rst_at/start_at name the cycle whose closing
    // edge sees that input (negative = never).
    task automatic run_job(input string name, input int k,
                           input logic [1:0] si, input logic [1:0] so,
                           input int abort_at, input int rst_at,
                           input int start_at);
        logic [2:0] ph;
        logic [9:0] ctl;
        logic       killed;
        int         total;
        total  = 3*H + W + k;
        killed = 1'b0;
        @(negedge clk);
        start         = 1'b1;
        cfg_k_len     = k[7:0];
        cfg_smart_in  = si;
        cfg_smart_out = so;
        @(posedge clk);
        for (int i = 1; i <= total + 2; i++) begin
            @(negedge clk);
            start         = 1'b0;
            abort         = 1'b0;
            rst           = 1'b1;
            cfg_k_len     = 8'hA5;
            cfg_smart_in  = ~si;
            cfg_smart_out = ~so;
            ph  = killed ? 3'd0 : exp_phase(i, k);
            ctl = exp_ctl(ph, si, so);
            checks++;
            if ({phase, busy, done, dut_ctl} !==
                {ph, (ph != 3'd0), (ph == 3'd5), ctl}) begin
                errors++;
                $display("FAIL %s cyc %0d: phase=%0d busy=%b done=%b ctl=%b required phase=%0d busy=%b done=%b ctl=%b",
                         name, i, phase, busy, done, dut_ctl,
                         ph, (ph != 3'd0), (ph == 3'd5), ctl);
            end
            checks++;
            if (perf_busy_cycles !== perf_req()) begin
                errors++;
                $display("FAIL %s perf cyc %0d: got %0d required %0d",
                         name, i, perf_busy_cycles, perf_req());
            end
            if (ph != 3'd0) exp_perf++;
            if (i == abort_at) begin
                abort  = 1'b1;
                killed = 1'b1;
            end
            if (i == rst_at) begin
                rst      = 1'b0;
                killed   = 1'b1;
                exp_perf = 0;
            end
            if (i == start_at) start = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        start = 1'b1;
        abort = 1'b0;
        cfg_k_len     = 8'd3;
        cfg_smart_in  = 2'b11;
        cfg_smart_out = 2'b11;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({phase, busy, done, dut_ctl, perf_busy_cycles} !== '0) begin
            errors++;
            $display("FAIL reset_hold: phase=%0d busy=%b done=%b ctl=%b perf=%0d required all 0",
                     phase, busy, done, dut_ctl, perf_busy_cycles);
        end
        start = 1'b0;
        rst   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({phase, busy, done, dut_ctl, perf_busy_cycles} !== '0) begin
            errors++;
            $display("FAIL reset_idle: phase=%0d busy=%b ctl=%b perf=%0d required all 0",
                     phase, busy, dut_ctl, perf_busy_cycles);
        end
        exp_perf = 0;
    endtask

    task automatic test_basic();
        run_job("basic_k8", 8, 2'b00, 2'b01, -1, -1, -1);
    endtask

    task automatic test_smart_select();
        run_job("smart_sel", 3, 2'b11, 2'b10, -1, -1, -1);
    endtask

    task automatic test_k_zero();
        run_job("k_zero", 0, 2'b01, 2'b11, -1, -1, -1);
    endtask

    task automatic test_abort();
        run_job("abort_stream3", 8, 2'b11, 2'b11, H + 3, -1, -1);
        run_job("after_abort", 5, 2'b10, 2'b01, -1, -1, -1);
    endtask

    task automatic test_start_in_drain();
        // k=2: DRAIN covers cycles 14..17
        run_job("start_in_drain", 2, 2'b01, 2'b10, -1, -1, 15);
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        cfg_k_len = 8'd4;
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            checks++;
            if ({phase, busy, done, dut_ctl} !== '0 ||
                perf_busy_cycles !== perf_req()) begin
                errors++;
                $display("FAIL start_abort_idle %0d: phase=%0d busy=%b ctl=%b perf=%0d required idle perf=%0d",
                         i, phase, busy, dut_ctl, perf_busy_cycles, perf_req());
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset_mid_flush();
        // k=8: FLUSH covers cycles 13..19
        run_job("rst_mid_flush", 8, 2'b11, 2'b11, -1, 15, -1);
    endtask

    task automatic test_back_to_back();
        run_job("b2b_a", 1, 2'b00, 2'b00, -1, -1, -1);
        run_job("b2b_b", 4, 2'b11, 2'b11, -1, -1, -1);
    endtask

    task automatic test_max_len();
        run_job("k_max", 255, 2'b01, 2'b01, -1, -1, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_smart_select();
        test_k_zero();
        test_abort();
        test_start_in_drain();
        test_start_abort_idle();
        test_reset_mid_flush();
        test_back_to_back();
        test_max_len();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
